plab5_mcore_dma_engine: RTL and testbench
=========================================

// Module: plab5_mcore_dma_engine
// PURPOSE
//  DMA copy engine downstream of the DMA security checker. Accepts one checked command
//  (core path or debug path), moves p_nwords words src->dest over the memory port, then
//  acks. The debug path reads one word and returns it on db_debug_data.
// PARAMETERS
//  p_opaque_nbits  8   opaque field width
//  p_addr_nbits    32  address width
//  p_data_nbits    32  data width
//  p_req_cnbits    45  mem-req control width: type[44:42] opaque[41:34] addr[33:2] len[1:0]
//  p_resp_cnbits   13  mem-resp control width: type[12:10] opaque[9:2] len[1:0]
//  p_nwords        4   words per core copy command (>=1)
// PORTS
//  clk             in   1   clock
//  reset           in   1   synchronous, active-high
//  dma_val         in   1   core command valid
//  dma_rdy         out  1   engine can accept a command
//  dma_domain      in   1   command security domain
//  dma_src_addr    in   a   copy source byte address
//  dma_dest_addr   in   a   copy destination byte address
//  dma_req_control in   45  originating request control
//  dma_resp_control out 13  response control
//  dma_inst        in   1   0 = core command
//  dma_ack         out  1   one-cycle completion pulse (both paths)
//  dma_resp_domain out  1   domain of completed command
//  dma_db_val/_domain/_inst   in 1 each   debug command valid/domain/inst
//  dma_db_src_addr/_dest_addr in a        debug addresses (dest ignored)
//  dma_db_debug_data out d   debug read data
//  memreq_val/rdy  out/in 1  memory request handshake
//  memreq_type     out  1   0 read, 1 write
//  memreq_addr     out  a   word-aligned byte address
//  memreq_data     out  d   write data
//  memreq_domain   out  1   domain tag = captured command domain
//  memresp_val/rdy in/out 1 memory response handshake
//  memresp_data    in   d   read data
//  memresp_domain  in   1   response domain tag
// BEHAVIOUR
//  - States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE. Reset -> IDLE, count=0.
//  - Reset values (IDLE): dma_rdy=1; all other val/ack outputs 0; memresp_rdy=0.
//  - IDLE: dma_val wins over dma_db_val when both are high; the loser is not captured.
//    Capture domain, addresses, control and path flag; go to RD_REQ.
//  - RD_REQ: memreq_val=1, type=0, addr=src+4*count. Advance on memreq_rdy.
//  - RD_WAIT: memresp_rdy=1; on memresp_val latch data_reg.
//    Debug path -> DONE. Core path -> WR_REQ.
//  - WR_REQ: memreq_val=1, type=1, addr=dest+4*count, data=data_reg. Advance on rdy.
//  - WR_WAIT: memresp_rdy=1 until memresp_val. Then:
//    count==p_nwords-1 -> DONE; otherwise count++ -> RD_REQ.
//  - DONE (one cycle): dma_ack=1 and dma_resp_domain=captured domain.
//    dma_resp_control={req type, req opaque, 2'b00}. Debug path: db_debug_data=data_reg.
//    Next state IDLE, count=0.
//  - Address adds wrap modulo 2^a. Inputs are ignored outside IDLE.
//  - Reset mid-transfer aborts immediately; no ack is produced.
//  - Latency: 2+4*p_nwords cycles from capture to ack with zero-wait memory.
// CONFIGURATION
//  PLAB5_DMA_ENGINE_DOMAIN_CHECK_EN defined:
//    - In RD_WAIT, memresp_domain < captured domain aborts the command.
//    - No write is issued. Go to DONE with dma_resp_control[1:0]=2'b11 (error).
//    - Debug data is forced to 0.
//  Undefined: memresp_domain is ignored and len is always 2'b00.
// TESTING
//  1. Core cmd src=0x1000 dest=0x2000, zero-wait mem -> reads 0x1000..0x100C, writes 0x2000..0x200C
//     in order; single dma_ack at cycle 18.
//  2. Debug cmd src=0x3000, mem returns 0xDEADBEEF -> one read, no write; ack with db_debug_data=0xDEADBEEF.
//  3. dma_val and dma_db_val high together in IDLE -> core cmd served; debug ignored; dma_rdy=0 until ack+1.
//  4. src=0xFFFFFFF8 -> read addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 (wrap).
//  5. memreq_rdy held 0 for 5 cycles in WR_REQ -> memreq fields stable; then completes normally.
//  6. Reset asserted in WR_WAIT -> next cycle IDLE, dma_rdy=1, no ack.
//     With _EN defined: cmd domain 1, memresp_domain 0 -> no write, ack with len=2'b11.

Source files
------------

// File: rtl/plab5_mcore_dma_engine_if.sv
// Command, debug and memory-port signals of the DMA copy engine, bundled for drop-in wiring.
// master = the engine itself; slave = the checker/memory side that feeds it.
interface plab5_mcore_dma_engine_if #(
  parameter int p_addr_nbits  = 32,
  parameter int p_data_nbits  = 32,
  parameter int p_req_cnbits  = 45,
  parameter int p_resp_cnbits = 13
);
  logic                     dma_val;
  logic                     dma_rdy;
  logic                     dma_domain;
  logic [p_addr_nbits-1:0]  dma_src_addr;
  logic [p_addr_nbits-1:0]  dma_dest_addr;
  logic [p_req_cnbits-1:0]  dma_req_control;
  logic [p_resp_cnbits-1:0] dma_resp_control;
  logic                     dma_inst;
  logic                     dma_ack;
  logic                     dma_resp_domain;

  logic                     dma_db_val;
  logic                     dma_db_domain;
  logic                     dma_db_inst;
  logic [p_addr_nbits-1:0]  dma_db_src_addr;
  logic [p_addr_nbits-1:0]  dma_db_dest_addr;
  logic [p_data_nbits-1:0]  dma_db_debug_data;

  logic                     memreq_val;
  logic                     memreq_rdy;
  logic                     memreq_type;
  logic [p_addr_nbits-1:0]  memreq_addr;
  logic [p_data_nbits-1:0]  memreq_data;
  logic                     memreq_domain;

  logic                     memresp_val;
  logic                     memresp_rdy;
  logic [p_data_nbits-1:0]  memresp_data;
  logic                     memresp_domain;

  modport master (
    input  dma_val, dma_domain, dma_src_addr, dma_dest_addr, dma_req_control, dma_inst,
    output dma_rdy, dma_resp_control, dma_ack, dma_resp_domain,
    input  dma_db_val, dma_db_domain, dma_db_inst, dma_db_src_addr, dma_db_dest_addr,
    output dma_db_debug_data,
    output memreq_val, memreq_type, memreq_addr, memreq_data, memreq_domain,
    input  memreq_rdy,
    input  memresp_val, memresp_data, memresp_domain,
    output memresp_rdy
  );

  modport slave (
    output dma_val, dma_domain, dma_src_addr, dma_dest_addr, dma_req_control, dma_inst,
    input  dma_rdy, dma_resp_control, dma_ack, dma_resp_domain,
    output dma_db_val, dma_db_domain, dma_db_inst, dma_db_src_addr, dma_db_dest_addr,
    input  dma_db_debug_data,
    input  memreq_val, memreq_type, memreq_addr, memreq_data, memreq_domain,
    output memreq_rdy,
    output memresp_val, memresp_data, memresp_domain,
    input  memresp_rdy
  );
endinterface

// File: rtl/plab5_mcore_dma_engine.sv
// DMA copy engine: copies p_nwords words src->dest (core path) or reads one word (debug path).
// Optional PLAB5_DMA_ENGINE_DOMAIN_CHECK_EN aborts on a read response from a lower domain.
module plab5_mcore_dma_engine #(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  parameter int p_req_cnbits   = 45,
  parameter int p_resp_cnbits  = 13,
  parameter int p_nwords       = 4
) (
  input logic                   clk,
  input logic                   reset,
  plab5_mcore_dma_engine_if.master bus
);

  localparam int CNT_W    = (p_nwords > 1) ? $clog2(p_nwords) : 1;
  localparam int TYPE_LSB = p_req_cnbits - 3;
  localparam int OPQ_LSB  = TYPE_LSB - p_opaque_nbits;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      domain_q, domain_d;
  logic [p_addr_nbits-1:0]   src_q, src_d;
  logic [p_addr_nbits-1:0]   dest_q, dest_d;
  logic [2:0]                type_q, type_d;
  logic [p_opaque_nbits-1:0] opaque_q, opaque_d;
  logic                      dbg_q, dbg_d;
  logic [p_data_nbits-1:0]   data_q, data_d;
  logic [p_addr_nbits-1:0]   offset;
  logic [1:0]                len;
`ifdef PLAB5_DMA_ENGINE_DOMAIN_CHECK_EN
  logic                      err_q, err_d;
`endif
  logic                      unused_inputs;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      domain_q <= 1'b0;
      src_q    <= '0;
      dest_q   <= '0;
      type_q   <= '0;
      opaque_q <= '0;
      dbg_q    <= 1'b0;
      data_q   <= '0;
`ifdef PLAB5_DMA_ENGINE_DOMAIN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      domain_q <= domain_d;
      src_q    <= src_d;
      dest_q   <= dest_d;
      type_q   <= type_d;
      opaque_q <= opaque_d;
      dbg_q    <= dbg_d;
      data_q   <= data_d;
`ifdef PLAB5_DMA_ENGINE_DOMAIN_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    domain_d = domain_q;
    src_d    = src_q;
    dest_d   = dest_q;
    type_d   = type_q;
    opaque_d = opaque_q;
    dbg_d    = dbg_q;
    data_d   = data_q;
`ifdef PLAB5_DMA_ENGINE_DOMAIN_CHECK_EN
    err_d    = err_q;
    len      = err_q ? 2'b11 : 2'b00;
`else
    len      = 2'b00;
`endif
    offset   = p_addr_nbits'({count_q, 2'b00});

    bus.dma_rdy           = 1'b0;
    bus.dma_ack           = 1'b0;
    bus.dma_resp_domain   = 1'b0;
    bus.dma_resp_control  = '0;
    bus.dma_db_debug_data = '0;
    bus.memreq_val        = 1'b0;
    bus.memreq_type       = 1'b0;
    bus.memreq_addr       = src_q + offset;
    bus.memreq_data       = data_q;
    bus.memreq_domain     = domain_q;
    bus.memresp_rdy       = 1'b0;

    case (state_q)
      IDLE: begin
        bus.dma_rdy = 1'b1;
        count_d     = '0;
        // Core command has priority; a simultaneous debug command is dropped, not queued.
        if (bus.dma_val || bus.dma_db_val) begin
          domain_d = bus.dma_val ? bus.dma_domain : bus.dma_db_domain;
          src_d    = bus.dma_val ? bus.dma_src_addr : bus.dma_db_src_addr;
          dest_d   = bus.dma_val ? bus.dma_dest_addr : '0;
          dbg_d    = ~bus.dma_val;
          type_d   = bus.dma_req_control[p_req_cnbits-1 -: 3];
          opaque_d = bus.dma_req_control[TYPE_LSB-1 -: p_opaque_nbits];
`ifdef PLAB5_DMA_ENGINE_DOMAIN_CHECK_EN
          err_d    = 1'b0;
`endif
          state_d  = RD_REQ;
        end
      end
      RD_REQ: begin
        bus.memreq_val = 1'b1;
        if (bus.memreq_rdy) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        bus.memresp_rdy = 1'b1;
        if (bus.memresp_val) begin
          data_d  = bus.memresp_data;
          state_d = dbg_q ? DONE : WR_REQ;
`ifdef PLAB5_DMA_ENGINE_DOMAIN_CHECK_EN
          if (bus.memresp_domain < domain_q) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      WR_REQ: begin
        bus.memreq_val  = 1'b1;
        bus.memreq_type = 1'b1;
        bus.memreq_addr = dest_q + offset;
        if (bus.memreq_rdy) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        bus.memresp_rdy = 1'b1;
        if (bus.memresp_val) begin
          if (count_q == CNT_W'(p_nwords - 1)) begin
            state_d = DONE;
          end else begin
            count_d = count_q + CNT_W'(1);
            state_d = RD_REQ;
          end
        end
      end
      DONE: begin
        bus.dma_ack          = 1'b1;
        bus.dma_resp_domain  = domain_q;
        bus.dma_resp_control = p_resp_cnbits'({type_q, opaque_q, len});
`ifdef PLAB5_DMA_ENGINE_DOMAIN_CHECK_EN
        if (dbg_q && !err_q) bus.dma_db_debug_data = data_q;
`else
        if (dbg_q) bus.dma_db_debug_data = data_q;
`endif
        count_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PLAB5_DMA_ENGINE_DOMAIN_CHECK_EN
  always_comb unused_inputs = ^{bus.dma_inst, bus.dma_db_inst, bus.dma_db_dest_addr,
                                bus.dma_req_control[OPQ_LSB-1:0]};
`else
  always_comb unused_inputs = ^{bus.dma_inst, bus.dma_db_inst, bus.dma_db_dest_addr,
                                bus.dma_req_control[OPQ_LSB-1:0], bus.memresp_domain};
`endif

endmodule

// File: tb/tb_plab5_mcore_dma_engine.sv
// Directed bench for plab5_mcore_dma_engine with a zero-wait memory model on the negative edge.
module tb_plab5_mcore_dma_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  plab5_mcore_dma_engine_if #(
    .p_addr_nbits(32), .p_data_nbits(32), .p_req_cnbits(45), .p_resp_cnbits(13)
  ) bus ();

  plab5_mcore_dma_engine #(
    .p_opaque_nbits(8), .p_addr_nbits(32), .p_data_nbits(32),
    .p_req_cnbits(45), .p_resp_cnbits(13), .p_nwords(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic        log_type[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        dbg_ovr = 1'b0;

  function automatic logic [31:0] rd_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory: accepts a request on the cycle it is offered; read data is ready for the next cycle.
  always @(negedge clk) begin
    if (!reset && bus.memreq_val && bus.memreq_rdy) begin
      log_type.push_back(bus.memreq_type);
      log_addr.push_back(bus.memreq_addr);
      log_data.push_back(bus.memreq_data);
      if (!bus.memreq_type)
        bus.memresp_data = dbg_ovr ? 32'hDEADBEEF : rd_data(bus.memreq_addr);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    log_type.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  // First step is the capture edge; lat = edges from capture to the DONE cycle.
  task automatic run_to_ack(input int maxc, output int lat, output int nack,
                            output logic rdy_early, output logic [12:0] rc,
                            output logic rd, output logic [31:0] dd, output logic rdy_after);
    lat = -1; nack = 0; rdy_early = 1'b0; rc = '0; rd = 1'b0; dd = '0;
    for (int i = 1; i <= maxc && lat < 0; i++) begin
      step();
      if (i == 1) begin
        bus.dma_val    = 1'b0;
        bus.dma_db_val = 1'b0;
      end
      if (bus.dma_ack) begin
        lat = i; nack++;
        rc = bus.dma_resp_control; rd = bus.dma_resp_domain; dd = bus.dma_db_debug_data;
      end else if (bus.dma_rdy) begin
        rdy_early = 1'b1;
      end
    end
    step();
    rdy_after = bus.dma_rdy;
    if (bus.dma_ack) nack++;
  endtask

  task automatic check_copy(input string tag, input logic [31:0] src, input logic [31:0] dest);
    logic [31:0] sa, da;
    check({tag, "_nreq"}, 64'(log_addr.size()), 64'(8));
    for (int i = 0; i < 4; i++) begin
      sa = src + 32'(4 * i);
      da = dest + 32'(4 * i);
      if (log_addr.size() >= 2 * i + 2) begin
        check({tag, "_rd"}, {31'b0, log_type[2*i], log_addr[2*i]}, {31'b0, 1'b0, sa});
        check({tag, "_wr"}, {31'b0, log_type[2*i+1], log_addr[2*i+1]}, {31'b0, 1'b1, da});
        check({tag, "_wdata"}, 64'(log_data[2*i+1]), 64'(rd_data(sa)));
      end
    end
  endtask

  int          lat, nack;
  logic        rdy_early, rd, rdy_after;
  logic [12:0] rc;
  logic [31:0] dd;

  initial begin
    bus.dma_val = 1'b0; bus.dma_domain = 1'b0; bus.dma_inst = 1'b0;
    bus.dma_src_addr = '0; bus.dma_dest_addr = '0; bus.dma_req_control = '0;
    bus.dma_db_val = 1'b0; bus.dma_db_domain = 1'b0; bus.dma_db_inst = 1'b0;
    bus.dma_db_src_addr = '0; bus.dma_db_dest_addr = '0;
    bus.memreq_rdy = 1'b1; bus.memresp_val = 1'b1; bus.memresp_domain = 1'b1;

    // Reset state
    step(); step();
    check("rst_rdy",        64'(bus.dma_rdy),     64'(1));
    check("rst_ack",        64'(bus.dma_ack),     64'(0));
    check("rst_memreq_val", 64'(bus.memreq_val),  64'(0));
    check("rst_memresp_rdy",64'(bus.memresp_rdy), 64'(0));
    reset = 1'b0;

    // Core copy 0x1000 -> 0x2000; ack in cycle 18 counting the capture cycle as 1
    clear_log();
    bus.dma_val = 1'b1; bus.dma_domain = 1'b1;
    bus.dma_src_addr = 32'h1000; bus.dma_dest_addr = 32'h2000;
    bus.dma_req_control = {3'd5, 8'hA7, 32'h1000, 2'b01};
    run_to_ack(40, lat, nack, rdy_early, rc, rd, dd, rdy_after);
    check("t1_lat",     64'(lat),  64'(17));
    check("t1_nack",    64'(nack), 64'(1));
    check("t1_rc",      64'(rc),   64'({3'd5, 8'hA7, 2'b00}));
    check("t1_rdom",    64'(rd),   64'(1));
    check("t1_dbgdata", 64'(dd),   64'(0));
    check_copy("t1", 32'h1000, 32'h2000);

    // Debug read of 0x3000
    clear_log();
    dbg_ovr = 1'b1;
    bus.dma_db_val = 1'b1; bus.dma_db_domain = 1'b0;
    bus.dma_db_src_addr = 32'h3000; bus.dma_db_dest_addr = 32'h9999;
    bus.dma_req_control = {3'd1, 8'h42, 34'h0};
    run_to_ack(40, lat, nack, rdy_early, rc, rd, dd, rdy_after);
    dbg_ovr = 1'b0;
    check("t2_lat",     64'(lat),             64'(3));
    check("t2_nack",    64'(nack),            64'(1));
    check("t2_dbgdata", 64'(dd),              64'(32'hDEADBEEF));
    check("t2_rc",      64'(rc),              64'({3'd1, 8'h42, 2'b00}));
    check("t2_rdom",    64'(rd),              64'(0));
    check("t2_nreq",    64'(log_addr.size()), 64'(1));
    if (log_addr.size() >= 1)
      check("t2_rd", {31'b0, log_type[0], log_addr[0]}, {31'b0, 1'b0, 32'h3000});

    // Core and debug together: core wins, debug is never served
    clear_log();
    bus.dma_val = 1'b1; bus.dma_domain = 1'b0;
    bus.dma_src_addr = 32'h4000; bus.dma_dest_addr = 32'h5000;
    bus.dma_req_control = {3'd2, 8'h3C, 34'h0};
    bus.dma_db_val = 1'b1; bus.dma_db_domain = 1'b1; bus.dma_db_src_addr = 32'h6000;
    run_to_ack(40, lat, nack, rdy_early, rc, rd, dd, rdy_after);
    check("t3_lat",       64'(lat),       64'(17));
    check("t3_nack",      64'(nack),      64'(1));
    check("t3_rdy_early", 64'(rdy_early), 64'(0));
    check("t3_rdy_after", 64'(rdy_after), 64'(1));
    check("t3_rdom",      64'(rd),        64'(0));
    check("t3_rc",        64'(rc),        64'({3'd2, 8'h3C, 2'b00}));
    check_copy("t3", 32'h4000, 32'h5000);

    // Source address wraps past the top of the address space
    clear_log();
    bus.dma_val = 1'b1; bus.dma_domain = 1'b1;
    bus.dma_src_addr = 32'hFFFF_FFF8; bus.dma_dest_addr = 32'h0000_0010;
    run_to_ack(40, lat, nack, rdy_early, rc, rd, dd, rdy_after);
    check("t4_lat", 64'(lat), 64'(17));
    check_copy("t4", 32'hFFFF_FFF8, 32'h0000_0010);
    if (log_addr.size() >= 8)
      check("t4_rd2", 64'(log_addr[4]), 64'(32'h0000_0000));

    // Write request held off for 5 cycles; fields must stay put
    clear_log();
    bus.dma_val = 1'b1; bus.dma_domain = 1'b1;
    bus.dma_src_addr = 32'h0100; bus.dma_dest_addr = 32'h0200;
    step();
    bus.dma_val = 1'b0;
    step();
    bus.memreq_rdy = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      check("t5_stall_hdr", {30'b0, bus.memreq_val, bus.memreq_type, bus.memreq_addr},
            {30'b0, 1'b1, 1'b1, 32'h0200});
      check("t5_stall_data", 64'(bus.memreq_data), 64'(rd_data(32'h0100)));
      if (c < 4) step();
    end
    check("t5_nreq_stall", 64'(log_addr.size()), 64'(1));
    bus.memreq_rdy = 1'b1;
    run_to_ack(40, lat, nack, rdy_early, rc, rd, dd, rdy_after);
    check("t5_lat",  64'(lat),  64'(14));
    check("t5_nack", 64'(nack), 64'(1));
    check_copy("t5", 32'h0100, 32'h0200);

    // Reset while waiting for the write response: abort, no ack
    clear_log();
    bus.dma_val = 1'b1;
    bus.dma_src_addr = 32'h0A00; bus.dma_dest_addr = 32'h0B00;
    step();
    bus.dma_val = 1'b0;
    step();
    step();
    bus.memresp_val = 1'b0;
    step();
    check("t6_in_wrwait", {62'b0, bus.memresp_rdy, bus.memreq_val}, {62'b0, 1'b1, 1'b0});
    reset = 1'b1;
    step();
    check("t6_rdy",         64'(bus.dma_rdy),     64'(1));
    check("t6_ack",         64'(bus.dma_ack),     64'(0));
    check("t6_memreq_val",  64'(bus.memreq_val),  64'(0));
    check("t6_memresp_rdy", 64'(bus.memresp_rdy), 64'(0));
    reset = 1'b0;
    bus.memresp_val = 1'b1;
    nack = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.dma_ack) nack++;
    end
    check("t6_no_ack", 64'(nack), 64'(0));
    check("t6_nreq",   64'(log_addr.size()), 64'(2));

`ifdef PLAB5_DMA_ENGINE_DOMAIN_CHECK_EN
    // Response from a lower domain aborts the copy with an error length
    clear_log();
    bus.memresp_domain = 1'b0;
    bus.dma_val = 1'b1; bus.dma_domain = 1'b1;
    bus.dma_src_addr = 32'h0700; bus.dma_dest_addr = 32'h0800;
    bus.dma_req_control = {3'd3, 8'h11, 34'h0};
    run_to_ack(40, lat, nack, rdy_early, rc, rd, dd, rdy_after);
    bus.memresp_domain = 1'b1;
    check("en_lat",  64'(lat),             64'(3));
    check("en_nack", 64'(nack),            64'(1));
    check("en_rc",   64'(rc),              64'({3'd3, 8'h11, 2'b11}));
    check("en_nreq", 64'(log_addr.size()), 64'(1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
